mem_port_arbiter: RTL and testbench

//  Shares one single-ported, word-wide unified memory between the CPU instruction-fetch port and
//  the load/store port, for the multi-cycle/pipelined core replacing split imem/dmem.

---
 rtl/mem_port_arbiter.sv | 119 +++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported word memory between instruction fetch and load/store.
// Data side has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_port_arbiter #(
    parameter int MEM_AW       = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        RESP_IF,
        RESP_D_LD,
        RESP_D_ST
    } owner_e;

    owner_e        state_q, state_d;
    logic [CW-1:0] starve_cnt_q, starve_cnt_d;
    logic          force_if;
    logic          store_gnt;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:MEM_AW+2], if_addr[1:0],
                                d_addr[31:MEM_AW+2], d_addr[1:0]};

    always_comb begin
        force_if  = (starve_cnt_q == LIMIT);
        d_gnt     = rst_n & d_req & ~force_if;
        if_gnt    = rst_n & if_req & (~d_req | force_if);
        store_gnt = d_gnt & d_we;
        mem_en    = if_gnt | d_gnt;
        mem_we    = store_gnt;
        mem_be    = store_gnt ? d_be : 4'b0000;
        mem_wdata = store_gnt ? d_wdata : 32'd0;
        mem_addr  = '0;
        if (if_gnt) begin
            mem_addr = if_addr[MEM_AW+1:2];
        end else if (d_gnt) begin
            mem_addr = d_addr[MEM_AW+1:2];
        end
    end

    // The counter only measures an unbroken run of data wins against a waiting fetch.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && starve_cnt_q != LIMIT) begin
            starve_cnt_d = starve_cnt_q + CW'(1);
        end
    end

    always_comb begin
        state_d = IDLE;
        if (if_gnt) begin
            state_d = RESP_IF;
        end else if (d_gnt) begin
            state_d = d_we ? RESP_D_ST : RESP_D_LD;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = 32'd0;
        d_rvalid  = 1'b0;
        d_rdata   = 32'd0;
        if (rst_n) begin
            unique case (state_q)
                RESP_IF: begin
                    if_rvalid = 1'b1;
                    if_rdata  = mem_rdata;
                end
                RESP_D_LD: begin
                    d_rvalid = 1'b1;
                    d_rdata  = mem_rdata;
                end
                RESP_D_ST: begin
                    d_rvalid = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised and directed bench for mem_port_arbiter with a transaction-level reference model.
// The model tracks a shadow memory, a data-win streak and the response due next cycle.
module tb_mem_port_arbiter;

    localparam int AW  = 10;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic          if_gnt, if_rvalid;
    logic [31:0]   if_rdata;
    logic          d_req = 1'b0, d_we = 1'b0;
    logic [3:0]    d_be = '0;
    logic [31:0]   d_addr = '0, d_wdata = '0;
    logic          d_gnt, d_rvalid;
    logic [31:0]   d_rdata;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_AW(AW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] seed(int i);
        if (i == 3) return 32'hABCDEF11;
        return (32'(i) * 32'h9E3779B9) ^ 32'hC3A50F1E;
    endfunction

    // Bench-side memory: 1-cycle read latency, garbage on idle cycles.
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] rd_q = '0;
    logic        mem_init = 1'b0;
    assign mem_rdata = rd_q;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= seed(i);
            mem_init <= 1'b1;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we && mem_be[b]) mem[mem_addr][8*b+:8] <= mem_wdata[8*b+:8];
            rd_q <= mem[mem_addr];
        end else begin
            rd_q <= $urandom;
        end
    end

    logic [31:0] shadow [0:(1<<AW)-1];
    int          streak = 0;
    int          pend = 0;
    logic [31:0] pend_data = '0;
    int          checks = 0;
    int          failures = 0;
    bit          g_f, g_d;
    logic        a_if_gnt, a_d_gnt, a_if_rvalid, a_d_rvalid;
    logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic step();
        bit          ed, ef, ewe, eiv, edv;
        logic [31:0] ea, eird, edrd;
        int          ia, da;
        ia = int'(if_addr[AW+1:2]);
        da = int'(d_addr[AW+1:2]);
        @(negedge clk);
        ed   = rst_n && d_req && (streak < LIM);
        ef   = rst_n && if_req && !ed;
        ewe  = ed && d_we;
        ea   = ef ? 32'(ia) : ed ? 32'(da) : 32'd0;
        eiv  = rst_n && pend == 1;
        edv  = rst_n && (pend == 2 || pend == 3);
        eird = eiv ? pend_data : 32'd0;
        edrd = (rst_n && pend == 2) ? pend_data : 32'd0;
        chk("if_gnt", 32'(if_gnt), 32'(ef));
        chk("d_gnt", 32'(d_gnt), 32'(ed));
        chk("mem_en", 32'(mem_en), 32'(ef | ed));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_be", 32'(mem_be), ewe ? 32'(d_be) : 32'd0);
        chk("mem_addr", 32'(mem_addr), ea);
        chk("mem_wdata", mem_wdata, ewe ? d_wdata : 32'd0);
        chk("if_rvalid", 32'(if_rvalid), 32'(eiv));
        chk("if_rdata", if_rdata, eird);
        chk("d_rvalid", 32'(d_rvalid), 32'(edv));
        chk("d_rdata", d_rdata, edrd);
        a_if_gnt = if_gnt; a_d_gnt = d_gnt;
        a_if_rvalid = if_rvalid; a_d_rvalid = d_rvalid;
        a_if_rdata = if_rdata; a_d_rdata = d_rdata;
        a_mem_addr = 32'(mem_addr);
        g_f = ef; g_d = ed;
        @(posedge clk);
        if (!rst_n) begin
            streak = 0;
            pend   = 0;
        end else begin
            if (!if_req || ef) streak = 0;
            else if (ed) streak++;
            pend      = ef ? 1 : ed ? (d_we ? 3 : 2) : 0;
            pend_data = ef ? shadow[ia] : (ed && !d_we) ? shadow[da] : 32'd0;
            if (ewe)
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) shadow[da][8*b+:8] = d_wdata[8*b+:8];
        end
        #1;
    endtask

    function automatic logic [31:0] raddr();
        return ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    string s;

    initial begin
        for (int i = 0; i < (1 << AW); i++) shadow[i] = seed(i);

        // reset with both requests up: nothing may be granted
        rst_n = 1'b0; if_req = 1'b1; d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_gnt", 32'(a_if_gnt | a_d_gnt), 32'd0);
        end
        rst_n = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();

        // 1: fetch only
        if_req = 1'b1; if_addr = 32'h0C;
        step();
        chk("t1_gnt", 32'(a_if_gnt), 32'd1);
        chk("t1_addr", a_mem_addr, 32'd3);
        if_req = 1'b0;
        step();
        chk("t1_rvalid", 32'(a_if_rvalid), 32'd1);
        chk("t1_rdata", a_if_rdata, 32'hABCDEF11);

        // 2: store then load
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h12345678; d_be = 4'hF;
        step();
        chk("t2_st_gnt", 32'(a_d_gnt), 32'd1);
        d_we = 1'b0; d_wdata = 32'hFFFF_FFFF;
        step();
        chk("t2_st_rvalid", 32'(a_d_rvalid), 32'd1);
        chk("t2_st_rdata", a_d_rdata, 32'd0);
        d_req = 1'b0;
        step();
        chk("t2_ld_rdata", a_d_rdata, 32'h12345678);
        chk("t2_mem4", mem[4], 32'h12345678);

        // 3: contention
        if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        s = "";
        for (int k = 0; k < 10; k++) begin
            step();
            s = {s, a_d_gnt ? "D" : a_if_gnt ? "F" : "-"};
            chk("t3_excl", 32'(a_if_gnt & a_d_gnt), 32'd0);
        end
        checks++;
        if (s != "DDDDFDDDDF") begin
            failures++;
            $display("FAIL t3_pattern got=%s exp=DDDDFDDDDF", s);
        end
        if_req = 1'b0; d_req = 1'b0;
        step();

        // 4: alternating fetch / load
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                if_req = 1'b1; if_addr = 32'(k / 2 * 4); d_req = 1'b0;
            end else begin
                if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'(32'h14 + k / 2 * 4);
            end
            step();
            if (k > 0) begin
                chk("t4_rv", 32'(a_if_rvalid | a_d_rvalid), 32'd1);
                chk("t4_owner", 32'(a_if_rvalid), (k % 2 == 1) ? 32'd1 : 32'd0);
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        step();

        // 5: reset right after a load grant
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        step();
        chk("t5_gnt", 32'(a_d_gnt), 32'd1);
        d_req = 1'b0; rst_n = 1'b0;
        step();
        chk("t5_rv_rst", 32'(a_d_rvalid), 32'd0);
        rst_n = 1'b1;
        step();
        chk("t5_rv_after", 32'(a_d_rvalid | a_if_rvalid), 32'd0);
        if_req = 1'b1; if_addr = 32'h0C;
        step();
        chk("t5_f_gnt", 32'(a_if_gnt), 32'd1);
        if_req = 1'b0;
        step();
        chk("t5_f_rdata", a_if_rdata, 32'hABCDEF11);

        // 6: drop if_req at streak 3, then re-raise
        if_req = 1'b1; if_addr = 32'h08; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24;
        for (int k = 0; k < 3; k++) step();
        if_req = 1'b0;
        step();
        if_req = 1'b1;
        s = "";
        for (int k = 0; k < 5; k++) begin
            step();
            s = {s, a_d_gnt ? "D" : a_if_gnt ? "F" : "-"};
        end
        checks++;
        if (s != "DDDDF") begin
            failures++;
            $display("FAIL t6_pattern got=%s exp=DDDDF", s);
        end
        if_req = 1'b0; d_req = 1'b0;
        step();

        // randomised traffic, requests held until granted
        for (int c = 0; c < 3000; c++) begin
            if (!if_req || g_f) begin
                if_req  = ($urandom_range(0, 3) != 0);
                if_addr = raddr();
            end
            if (!d_req || g_d) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_be    = 4'($urandom);
                d_addr  = raddr();
                d_wdata = $urandom;
            end
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
